// File: rtl/vector_packer_pkg.sv
// Shared constants and helpers for the vector packer: condition bit positions,
// length encoding and output count sizing.
package vector_packer_pkg;

    // Condition byte bit positions; a set bit matches when its flag has the stated value.
    localparam int unsigned COND_EOF0_SET = 0;
    localparam int unsigned COND_EOF0_CLR = 1;
    localparam int unsigned COND_BOF0_SET = 2;
    localparam int unsigned COND_BOF0_CLR = 3;
    localparam int unsigned COND_EOF1_SET = 4;
    localparam int unsigned COND_EOF1_CLR = 5;
    localparam int unsigned COND_BOF1_SET = 6;
    localparam int unsigned COND_BOF1_CLR = 7;

    localparam logic [7:0] LEN_DISABLED = 8'd0;

    // Enough bits to hold 0..lanes inclusive.
    function automatic int unsigned count_width(input int unsigned lanes);
        return $clog2(lanes) + 1;
    endfunction

    function automatic logic cond_match(input logic [7:0] cond, input logic [1:0] eof,
                                        input logic [1:0] bof);
        logic [7:0] hit;
        hit                = '0;
        hit[COND_EOF0_SET] = eof[0];
        hit[COND_EOF0_CLR] = ~eof[0];
        hit[COND_BOF0_SET] = bof[0];
        hit[COND_BOF0_CLR] = ~bof[0];
        hit[COND_EOF1_SET] = eof[1];
        hit[COND_EOF1_CLR] = ~eof[1];
        hit[COND_BOF1_SET] = bof[1];
        hit[COND_BOF1_CLR] = ~bof[1];
        return (cond == 8'd0) || ((cond & hit) != 8'd0);
    endfunction

endpackage

// File: rtl/packer_out_fifo.sv
// Two-entry output queue for packed vectors. The head entry drives the outputs
// directly; up to two entries may be pushed in one cycle.
module packer_out_fifo #(
    parameter int unsigned N          = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CW         = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push0,
    input  logic [N-1:0][DATA_WIDTH-1:0]     push0_data,
    input  logic [CW-1:0]                    push0_cnt,
    input  logic                             push1,
    input  logic [N-1:0][DATA_WIDTH-1:0]     push1_data,
    input  logic [CW-1:0]                    push1_cnt,
    input  logic                             ready_in,
    output logic [N-1:0][DATA_WIDTH-1:0]     vector_out,
    output logic [CW-1:0]                    count_out,
    output logic                             valid_out,
    output logic                             empty
);

    logic [1:0]                            vld_q, vld_d;
    logic [1:0][N-1:0][DATA_WIDTH-1:0]     data_q, data_d;
    logic [1:0][CW-1:0]                    cnt_q, cnt_d;
    logic                                  pop;

    assign pop = vld_q[0] & ready_in;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        // Popped slots are zeroed so an idle output reads all zero.
        if (pop) begin
            vld_d     = {1'b0, vld_q[1]};
            data_d[0] = data_q[1];
            cnt_d[0]  = cnt_q[1];
            data_d[1] = '0;
            cnt_d[1]  = '0;
        end
        if (push0) begin
            if (!vld_d[0]) begin
                data_d[0] = push0_data;
                cnt_d[0]  = push0_cnt;
                vld_d[0]  = 1'b1;
            end else begin
                data_d[1] = push0_data;
                cnt_d[1]  = push0_cnt;
                vld_d[1]  = 1'b1;
            end
        end
        if (push1) begin
            data_d[1] = push1_data;
            cnt_d[1]  = push1_cnt;
            vld_d[1]  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign vector_out = data_q[0];
    assign count_out  = cnt_q[0];
    assign valid_out  = vld_q[0];
    assign empty      = ~|vld_q;

endmodule

// File: rtl/vector_packer.sv
// Packs variable-length lane groups selected by per-chain firmware entries into
// N-lane output vectors, with flush on outer end-of-frame.
module vector_packer
    import vector_packer_pkg::*;
#(
    parameter int unsigned N                  = 8,
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned MAX_CHAINS         = 4,
    parameter int unsigned PERSONAL_CONFIG_ID = 0
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    input  logic                                                    tracing,
    input  logic                                                    valid_in,
    output logic                                                    ready_out,
    input  logic [1:0]                                              eof_in,
    input  logic [1:0]                                              bof_in,
    input  logic [((MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1)-1:0]  chainId_in,
    input  logic [7:0]                                              configId,
    input  logic [7:0]                                              configData,
    input  logic [N-1:0][DATA_WIDTH-1:0]                            vector_in,
    output logic [N-1:0][DATA_WIDTH-1:0]                            vector_out,
    output logic [count_width(N)-1:0]                               count_out,
    output logic                                                    valid_out,
    input  logic                                                    ready_in
);

    localparam int unsigned CW  = count_width(N);
    localparam int unsigned CHW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
    localparam int unsigned LW  = $clog2(N);
    localparam logic [8:0]  NSUM = 9'(N);

    typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

    vec_t                       hold_q, hold_d, merged, fresh, push0_data;
    logic [CW-1:0]              cnt_q, cnt_d, push0_cnt;
    logic [MAX_CHAINS-1:0][7:0] len_q, len_d, cond_q, cond_d;
    logic [7:0]                 cfg_cnt_q, cfg_cnt_d;
    logic                       rdy_q;
    logic [7:0]                 sel_len, sel_cond;
    logic                       len_ok, accept, flush, fifo_empty;
    logic                       push0, push1;
    logic [8:0]                 sum;

    always_comb begin
        sel_len  = LEN_DISABLED;
        sel_cond = '0;
        for (int c = 0; c < int'(MAX_CHAINS); c++) begin
            if (chainId_in == CHW'(c)) begin
                sel_len  = len_q[c];
                sel_cond = cond_q[c];
            end
        end
    end

    assign ready_out = rdy_q & fifo_empty;
    assign len_ok    = (sel_len != LEN_DISABLED) && (int'(sel_len) <= int'(N));
    assign accept    = valid_in & ready_out & tracing & len_ok
                       & cond_match(sel_cond, eof_in, bof_in);
    assign flush     = eof_in[1];
    assign sum       = {1'b0, sel_len} + 9'(cnt_q);

    // Held lanes above cnt are always zero, so appending only fills [cnt, cnt+L).
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            fresh[i]  = (i < int'(sel_len)) ? vector_in[i] : '0;
            merged[i] = hold_q[i];
            if (i >= int'(cnt_q) && i < int'(sum)) begin
                merged[i] = vector_in[LW'(i - int'(cnt_q))];
            end
        end
    end

    always_comb begin
        hold_d     = hold_q;
        cnt_d      = cnt_q;
        push0      = 1'b0;
        push1      = 1'b0;
        push0_data = merged;
        push0_cnt  = CW'(sum);
        if (accept) begin
            if (sum <= NSUM) begin
                if (flush || sum == NSUM) begin
                    push0  = 1'b1;
                    hold_d = '0;
                    cnt_d  = '0;
                end else begin
                    hold_d = merged;
                    cnt_d  = CW'(sum);
                end
            end else begin
                // Overflow: the held partial vector goes out first.
                push0      = 1'b1;
                push0_data = hold_q;
                push0_cnt  = cnt_q;
                if (flush || int'(sel_len) == int'(N)) begin
                    push1  = 1'b1;
                    hold_d = '0;
                    cnt_d  = '0;
                end else begin
                    hold_d = fresh;
                    cnt_d  = CW'(sel_len);
                end
            end
        end
    end

    always_comb begin
        cond_d    = cond_q;
        len_d     = len_q;
        cfg_cnt_d = '0;
        if (!tracing && configId == 8'(PERSONAL_CONFIG_ID)) begin
            for (int c = 0; c < int'(MAX_CHAINS); c++) begin
                if (int'(cfg_cnt_q) == c) cond_d[c] = configData;
                if (int'(cfg_cnt_q) == c + int'(MAX_CHAINS)) len_d[c] = configData;
            end
            cfg_cnt_d = (cfg_cnt_q == 8'hFF) ? cfg_cnt_q : cfg_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            cond_q    <= '0;
            cfg_cnt_q <= '0;
            rdy_q     <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            cond_q    <= cond_d;
            cfg_cnt_q <= cfg_cnt_d;
            rdy_q     <= 1'b1;
        end
    end

    packer_out_fifo #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH),
        .CW         (CW)
    ) u_out_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push0      (push0),
        .push0_data (push0_data),
        .push0_cnt  (push0_cnt),
        .push1      (push1),
        .push1_data (fresh),
        .push1_cnt  (CW'(sel_len)),
        .ready_in   (ready_in),
        .vector_out (vector_out),
        .count_out  (count_out),
        .valid_out  (valid_out),
        .empty      (fifo_empty)
    );

endmodule

// File: tb/tb_vector_packer.sv
// Directed self-checking bench for vector_packer (N=8, 32-bit lanes, 4 chains).
module tb_vector_packer;

    localparam int N  = 8;
    localparam int DW = 32;

    typedef logic [N-1:0][DW-1:0] vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tracing = 1'b1;
    logic       valid_in = 1'b0;
    logic       ready_in = 1'b1;
    logic [1:0] eof_in = '0;
    logic [1:0] bof_in = '0;
    logic [1:0] chain_id = '0;
    logic [7:0] config_id = '0;
    logic [7:0] config_data = '0;
    vec_t       vector_in = '0;
    vec_t       vector_out;
    logic [3:0] count_out;
    logic       valid_out;
    logic       ready_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vector_packer #(
        .N                  (N),
        .DATA_WIDTH         (DW),
        .MAX_CHAINS         (4),
        .PERSONAL_CONFIG_ID (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tracing    (tracing),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .eof_in     (eof_in),
        .bof_in     (bof_in),
        .chainId_in (chain_id),
        .configId   (config_id),
        .configData (config_data),
        .vector_in  (vector_in),
        .vector_out (vector_out),
        .count_out  (count_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [31:0] base);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = base + 32'(i);
        return v;
    endfunction

    // Wait (bounded) for ready_out, present one input for one edge, sample at the next negedge.
    task automatic send(input logic [1:0] chain, input vec_t v, input logic [1:0] eof);
        int guard = 0;
        while (!ready_out && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", 256'(ready_out), 256'd1);
        valid_in  = 1'b1;
        chain_id  = chain;
        vector_in = v;
        eof_in    = eof;
        @(posedge clk);
        @(negedge clk);
        valid_in  = 1'b0;
        eof_in    = '0;
    endtask

    // Byte i of the stream is bits [8*i +: 8].
    task automatic configure(input logic [63:0] bytes);
        tracing   = 1'b0;
        config_id = 8'd0;
        for (int i = 0; i < 8; i++) begin
            config_data = bytes[i*8 +: 8];
            @(posedge clk);
            @(negedge clk);
        end
        tracing = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t ev;
        vec_t v;

        // Reset state
        @(negedge clk);
        check("rst_valid", 256'(valid_out), 256'd0);
        check("rst_count", 256'(count_out), 256'd0);
        check("rst_vector", vector_out, 256'd0);
        check("rst_ready", 256'(ready_out), 256'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 256'(ready_out), 256'd1);

        // lens {1,3,2,8}, conds all 0
        configure(64'h0802030100000000);

        // Eight single-lane accepts fill one vector
        for (int k = 1; k <= 8; k++) begin
            v    = mkv(32'hDEAD0000);
            v[0] = 32'(k);
            send(2'd0, v, 2'b00);
            if (k == 7) check("len1_no_early_out", 256'(valid_out), 256'd0);
        end
        for (int i = 0; i < N; i++) ev[i] = 32'(i + 1);
        check("len1_valid", 256'(valid_out), 256'd1);
        check("len1_count", 256'(count_out), 256'd8);
        check("len1_vector", vector_out, ev);
        @(negedge clk);
        check("len1_popped", 256'(valid_out), 256'd0);

        // len=3 overflow emits partial A,B
        send(2'd1, mkv(32'hA0), 2'b00);
        send(2'd1, mkv(32'hB0), 2'b00);
        send(2'd1, mkv(32'hC0), 2'b00);
        ev = '0;
        for (int i = 0; i < 3; i++) begin
            ev[i]     = 32'hA0 + 32'(i);
            ev[3 + i] = 32'hB0 + 32'(i);
        end
        check("ovf_count", 256'(count_out), 256'd6);
        check("ovf_vector", vector_out, ev);

        // Flush behind held C
        send(2'd2, mkv(32'hD0), 2'b10);
        ev = '0;
        for (int i = 0; i < 3; i++) ev[i] = 32'hC0 + 32'(i);
        ev[3] = 32'hD0;
        ev[4] = 32'hD1;
        check("held_flush_count", 256'(count_out), 256'd5);
        check("held_flush_vector", vector_out, ev);

        // len=2 twice, second flushes
        send(2'd2, mkv(32'hE0), 2'b00);
        send(2'd2, mkv(32'hF0), 2'b10);
        ev    = '0;
        ev[0] = 32'hE0;
        ev[1] = 32'hE1;
        ev[2] = 32'hF0;
        ev[3] = 32'hF1;
        check("flush4_count", 256'(count_out), 256'd4);
        check("flush4_vector", vector_out, ev);

        // cnt back at 0: a full-width group emits alone
        send(2'd3, mkv(32'h6000), 2'b00);
        check("full_count", 256'(count_out), 256'd8);
        check("full_vector", vector_out, mkv(32'h6000));
        @(negedge clk);

        // Back-pressure: partial + full queued together
        ready_in = 1'b0;
        send(2'd1, mkv(32'h7000), 2'b00);
        send(2'd3, mkv(32'h8000), 2'b00);
        ev = '0;
        for (int i = 0; i < 3; i++) ev[i] = 32'h7000 + 32'(i);
        check("stall_ready", 256'(ready_out), 256'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_vector_stable", vector_out, ev);
        end
        check("stall_count", 256'(count_out), 256'd3);
        check("stall_ready_held", 256'(ready_out), 256'd0);
        ready_in = 1'b1;
        @(negedge clk);
        check("release_second_valid", 256'(valid_out), 256'd1);
        check("release_second_count", 256'(count_out), 256'd8);
        check("release_second_vector", vector_out, mkv(32'h8000));
        @(negedge clk);
        check("release_drained", 256'(valid_out), 256'd0);
        check("release_ready", 256'(ready_out), 256'd1);

        // Reconfigure: conds {0,1,0,0}, lens {8,2,1,0}
        configure(64'h0001020800000100);
        send(2'd1, mkv(32'h9000), 2'b00);
        check("cond_reject", 256'(valid_out), 256'd0);
        send(2'd1, mkv(32'h9100), 2'b11);
        ev    = '0;
        ev[0] = 32'h9100;
        ev[1] = 32'h9101;
        check("cond_accept_count", 256'(count_out), 256'd2);
        check("cond_accept_vector", vector_out, ev);
        send(2'd3, mkv(32'h9200), 2'b10);
        check("chain3_disabled", 256'(valid_out), 256'd0);
        send(2'd2, mkv(32'h9300), 2'b10);
        ev    = '0;
        ev[0] = 32'h9300;
        check("len1_flush_count", 256'(count_out), 256'd1);
        check("len1_flush_vector", vector_out, ev);

        // Fill to cnt=5, queue outputs, then reset mid-cycle
        for (int k = 0; k < 5; k++) send(2'd2, mkv(32'h500 + 32'(k)), 2'b00);
        ready_in = 1'b0;
        send(2'd0, mkv(32'h5100), 2'b00);
        check("pre_rst_count", 256'(count_out), 256'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 256'(valid_out), 256'd0);
        check("mid_rst_count", 256'(count_out), 256'd0);
        check("mid_rst_vector", vector_out, 256'd0);
        check("mid_rst_ready", 256'(ready_out), 256'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        ready_in = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 256'(ready_out), 256'd1);
        send(2'd0, mkv(32'h5200), 2'b10);
        check("post_rst_len_cleared", 256'(valid_out), 256'd0);
        configure(64'h0001020800000100);
        send(2'd0, mkv(32'h5A00), 2'b00);
        check("post_rst_full_count", 256'(count_out), 256'd8);
        check("post_rst_full_vector", vector_out, mkv(32'h5A00));
        @(negedge clk);
        check("post_rst_single_out", 256'(valid_out), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
